// File: rtl/gnr_cycle_ctrl.sv
// Drives the node array of a GNR simulator as a tortoise/hare pair (s0 one step,
// s1 two steps per round) and reports the attractor state and step count.
module gnr_cycle_ctrl #(
  parameter int N_NODES   = 8,
  parameter int STEP_W    = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_valid,
  output logic               init_ready,
  input  logic [N_NODES-1:0] init_data,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_NODES-1:0] res_state,
  output logic [STEP_W-1:0]  res_steps,
  output logic               res_timeout,
  output logic               busy
);

  localparam logic [STEP_W-1:0] MAX_C = STEP_W'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STEP0, S_STEP1, S_CMP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               arm_q;
  logic [N_NODES-1:0] init_state_q, init_state_d;
  logic [STEP_W-1:0]  steps_q, steps_d, steps_inc;
  logic [N_NODES-1:0] res_state_q, res_state_d;
  logic [STEP_W-1:0]  res_steps_q, res_steps_d;
  logic               res_timeout_q, res_timeout_d;

  assign steps_inc = steps_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    init_state_d  = init_state_q;
    steps_d       = steps_q;
    res_state_d   = res_state_q;
    res_steps_d   = res_steps_q;
    res_timeout_d = res_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (init_valid && arm_q) begin
          init_state_d = init_data;
          steps_d      = '0;
          state_d      = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_STEP0;
      S_STEP0: state_d = S_STEP1;
      S_STEP1: state_d = S_CMP;
      S_CMP: begin
        if (steps_q != MAX_C) steps_d = steps_inc;
        // A meeting wins over an exhausted budget on the same round.
        if (s0_vec == s1_vec) begin
          res_state_d   = s0_vec;
          res_steps_d   = steps_inc;
          res_timeout_d = 1'b0;
          state_d       = S_DONE;
        end else if (steps_inc == MAX_C) begin
          res_state_d   = s0_vec;
          res_steps_d   = MAX_C;
          res_timeout_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          state_d = S_STEP0;
        end
      end
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // arm_q keeps init_ready low while rst is held and sets on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      arm_q         <= 1'b0;
      init_state_q  <= '0;
      steps_q       <= '0;
      res_state_q   <= '0;
      res_steps_q   <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      arm_q         <= 1'b1;
      init_state_q  <= init_state_d;
      steps_q       <= steps_d;
      res_state_q   <= res_state_d;
      res_steps_q   <= res_steps_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign init_ready  = (state_q == S_IDLE) && arm_q;
  assign reset_nos   = (state_q == S_LOAD);
  assign start_s0    = (state_q == S_STEP0) || (state_q == S_STEP1);
  assign start_s1    = start_s0;
  assign res_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign init_state  = init_state_q;
  assign res_state   = res_state_q;
  assign res_steps   = res_steps_q;
  assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_gnr_cycle_ctrl.sv
// Two controllers (budget 300 and 100) each driving a behavioural node array;
// results are compared against a direct tortoise/hare iteration of the network.
module tb_gnr_cycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv [2];
  logic [7:0] id [2];
  logic       rr [2];
  logic       ir [2], rn [2], ss0 [2], ss1 [2], rv [2], rto [2], bsy [2];
  logic [7:0] ist [2], s0v [2], s1v [2], rstate [2];
  logic [15:0] rsteps [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gnr_cycle_ctrl #(.N_NODES(8), .STEP_W(16), .MAX_STEPS(g == 0 ? 300 : 100)) u_dut (
      .clk(clk), .rst(rst),
      .init_valid(iv[g]), .init_ready(ir[g]), .init_data(id[g]),
      .reset_nos(rn[g]), .init_state(ist[g]),
      .start_s0(ss0[g]), .start_s1(ss1[g]),
      .s0_vec(s0v[g]), .s1_vec(s1v[g]),
      .res_valid(rv[g]), .res_ready(rr[g]),
      .res_state(rstate[g]), .res_steps(rsteps[g]), .res_timeout(rto[g]),
      .busy(bsy[g])
    );
  end

  // network: 0 identity, 1 counter, 2 random lookup table
  int         mode [2];
  logic [7:0] lut [256];

  function automatic logic [7:0] nf(input int m, input logic [7:0] x);
    case (m)
      0:       return x;
      1:       return x + 8'd1;
      default: return lut[x];
    endcase
  endfunction

  // node array: s0 advances on every second start_s0 strobe after a load
  logic pass [2];
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rn[g]) begin
        s0v[g]  <= ist[g];
        s1v[g]  <= ist[g];
        pass[g] <= 1'b1;
      end else begin
        if (ss1[g]) s1v[g] <= nf(mode[g], s1v[g]);
        if (ss0[g]) begin
          if (pass[g]) s0v[g] <= nf(mode[g], s0v[g]);
          pass[g] <= ~pass[g];
        end
      end
    end
  end

  int s0cnt [2], s1cnt [2], hs [2];
  int viol = 0;
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (iv[g] && ir[g]) begin
        hs[g]++;
        s0cnt[g] = 0;
        s1cnt[g] = 0;
      end else begin
        if (ss0[g]) s0cnt[g]++;
        if (ss1[g]) s1cnt[g]++;
      end
    end
  end
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if ((ss0[g] || ss1[g]) && rn[g]) viol++;
      if (rv[g] && (ss0[g] || ss1[g])) viol++;
      if (ss0[g] && !bsy[g]) viol++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // reference: plain Floyd iteration of the network function
  task automatic ref_run(input int m, input logic [7:0] init, input int maxs,
                         output logic [7:0] st, output int steps, output bit to);
    logic [7:0] a, b;
    a = init; b = init; to = 1'b0; steps = 0; st = init;
    for (int k = 1; k <= maxs; k++) begin
      a = nf(m, a);
      b = nf(m, nf(m, b));
      steps = k; st = a;
      if (a == b) return;
    end
    to = 1'b1;
  endtask

  // called on a negedge; returns on the negedge right after the handshake edge
  task automatic start_job(input int g, input logic [7:0] d, input bit hold);
    bit ok;
    iv[g] = 1'b1; id[g] = d; ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (ir[g]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept_wait", 32'(ok), 1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) iv[g] = 1'b0;
    chk("reset_nos_t1", 32'(rn[g]), 1);
  endtask

  task automatic finish_job(input int g, input logic [7:0] init, input int bp, input int explat);
    logic [7:0] es; int est; bit eto; bit got; bit stable; int k;
    ref_run(mode[g], init, (g == 0) ? 300 : 100, es, est, eto);
    got = 1'b0; k = 1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk); k++;
      if (rv[g]) begin got = 1'b1; break; end
    end
    chk("res_wait", 32'(got), 1);
    if (!got) return;
    if (explat > 0) chk("res_latency", k, explat);
    chk("res_state", 32'(rstate[g]), 32'(es));
    chk("res_steps", 32'(rsteps[g]), est);
    chk("res_timeout", 32'(rto[g]), 32'(eto));
    chk("s0_strobes", s0cnt[g], 2 * est);
    chk("s1_strobes", s1cnt[g], 2 * est);
    if (bp > 0) begin
      stable = 1'b1;
      for (int c = 0; c < bp; c++) begin
        @(negedge clk);
        if (!rv[g] || ir[g] || rstate[g] != es || 32'(rsteps[g]) != est || rto[g] != eto) stable = 1'b0;
      end
      chk("bp_stable", 32'(stable), 1);
    end
    rr[g] = 1'b1;
    @(negedge clk);
    chk("res_valid_drop", 32'(rv[g]), 0);
    chk("ready_back", 32'(ir[g]), 1);
    rr[g] = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int base;
    for (int g = 0; g < 2; g++) begin
      iv[g] = 1'b0; id[g] = '0; rr[g] = 1'b0; mode[g] = 0;
      s0cnt[g] = 0; s1cnt[g] = 0; hs[g] = 0;
    end
    for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    chk("rst_init_ready", 32'(ir[0]), 0);
    chk("rst_busy", 32'(bsy[0]), 0);
    chk("rst_res_valid", 32'(rv[0]), 0);
    chk("rst_strobes", 32'({rn[0], ss0[0], ss1[0]}), 0);
    chk("rst_res", 32'({rstate[0], rsteps[0], rto[0]}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_init_ready", 32'(ir[0]), 1);

    // identity network: result one step in, latency t+5
    mode[0] = 0;
    start_job(0, 8'hA5, 1'b0);
    finish_job(0, 8'hA5, 0, 5);

    // counter network meets after 256 steps; budget 100 times out
    mode[0] = 1;
    start_job(0, 8'h00, 1'b0);
    finish_job(0, 8'h00, 0, 0);
    mode[1] = 1;
    start_job(1, 8'h00, 1'b0);
    finish_job(1, 8'h00, 0, 0);

    // backpressure in DONE
    mode[0] = 2;
    d = 8'($urandom);
    start_job(0, d, 1'b0);
    finish_job(0, d, 20, 0);

    // async reset between edges during STEP1
    start_job(0, 8'($urandom), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 chk("step1_strobe", 32'(ss1[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_s0", 32'(ss0[0]), 0);
    chk("arst_s1", 32'(ss1[0]), 0);
    chk("arst_busy", 32'(bsy[0]), 0);
    chk("arst_valid", 32'(rv[0]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_ready", 32'(ir[0]), 1);
    d = 8'($urandom);
    start_job(0, d, 1'b0);
    finish_job(0, d, 0, 0);

    // init_valid held across two jobs: second word waits for DONE handshake
    base = hs[0];
    d = 8'($urandom);
    start_job(0, d, 1'b1);
    id[0] = 8'($urandom);
    finish_job(0, d, 3, 0);
    chk("hold_one_accept", hs[0] - base, 1);
    d = id[0];
    start_job(0, d, 1'b0);
    finish_job(0, d, 0, 0);

    // random networks and starting states on both controllers
    for (int j = 0; j < 10; j++) begin
      int g;
      g = j % 2;
      mode[g] = 2;
      for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);
      d = 8'($urandom);
      start_job(g, d, 1'b0);
      finish_job(g, d, int'($urandom_range(0, 3)), 0);
    end

    chk("protocol", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gnr_cycle_ctrl.md
Name: gnr_cycle_ctrl

Overview:
Network-side controller that drives the node-update interface of a gene-regulatory-network (GNR) simulation array.
- Loads an initial state into every node.
- Runs the slow (s0) and fast (s1) node copies as a Floyd tortoise/hare pair.
- Detects when s0 and s1 state vectors meet, i.e. an attractor has been reached.
- Returns the meeting state and step count through a valid/ready result port.
- Sits between a host-side init-state stream and the node array.

Parameters:
N_NODES, 8, number of network nodes (width of state vectors)
STEP_W, 16, width of step counter
MAX_STEPS, 1000, s0 step budget before timeout; must be < 2^STEP_W

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
init_valid  in  1  initial-state word available
init_ready  out  1  controller accepts initial state
init_data  in  N_NODES  initial state, bit i for node i
reset_nos  out  1  node load strobe (nodes load init_state, arm s0 pass)
init_state  out  N_NODES  per-node initial value, bit i to node i
start_s0  out  1  step enable for s0 copy (nodes advance s0 on every second strobe)
start_s1  out  1  step enable for s1 copy (nodes advance s1 on every strobe)
s0_vec  in  N_NODES  concatenated node s0 outputs
s1_vec  in  N_NODES  concatenated node s1 outputs
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_state  out  N_NODES  s0_vec captured at meeting (or at timeout)
res_steps  out  STEP_W  number of s0 steps taken
res_timeout  out  1  1 = budget exhausted without meeting
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs are 0, except init_ready=1 once in IDLE after reset release.
  - init_state register, step counter and result registers are cleared.
- All outputs are decoded from registered state; there is no combinational path from inputs to outputs.
- IDLE:
  - init_ready=1.
  - On init_valid&init_ready: latch init_data into init_state, clear steps, go to LOAD.
- LOAD (1 cycle):
  - reset_nos=1.
  - Next state STEP0.
- STEP0 (1 cycle):
  - start_s0=start_s1=1.
  - The node pass flag is armed, so s0 and s1 both advance.
  - Next state STEP1.
- STEP1 (1 cycle):
  - start_s0=start_s1=1.
  - s1 advances; s0 holds (pass consumed).
  - Next state CMP.
- CMP (1 cycle):
  - No strobes; vectors are settled (s0 +1 step, s1 +2 steps since last CMP).
  - Increment steps (saturating at MAX_STEPS).
  - If s0_vec==s1_vec: capture res_state=s0_vec, res_steps=steps+1, res_timeout=0, go to DONE.
  - Else if steps+1==MAX_STEPS: capture res_state=s0_vec, res_steps=MAX_STEPS, res_timeout=1, go to DONE.
  - Else go to STEP0.
  - A match takes precedence over timeout in the same cycle.
- DONE:
  - res_valid=1; res_* held stable until handshake.
  - On res_ready: res_valid drops next cycle, go to IDLE.
  - init_ready=0 while in DONE; no back-to-back acceptance.
- Timing:
  - Each s0 step costs 3 cycles.
  - From an init handshake at cycle t: reset_nos at t+1, first CMP at t+4, earliest res_valid at t+5.
- Strobe rules:
  - start_s0 and start_s1 are never asserted together with reset_nos.
  - Strobes are asserted only in STEP0/STEP1.
- init_data is ignored unless in IDLE.
- Async reset mid-run:
  - Strobes drop immediately.
  - Any pending result is discarded.
  - The node array is not reloaded until the next init handshake.
- Counter arithmetic: unsigned; steps never wraps because of the MAX_STEPS < 2^STEP_W constraint.

Test Plan:
- Bench node model with identity network (next=state), init_data=8'hA5 accepted at cycle t -> reset_nos at t+1, strobes at t+2..t+3, res_valid at t+5 with res_state=8'hA5, res_steps=1, res_timeout=0.
- Counter network (next=state+1 mod 256), init 8'h00, MAX_STEPS=300 -> res_steps=256, res_state=8'h00, res_timeout=0; exactly 512 start_s1 strobes and 512 start_s0 strobes.
- Same counter network with MAX_STEPS=100 -> res_timeout=1, res_steps=100, res_state=8'd100.
- Backpressure: hold res_ready=0 for 20 cycles in DONE -> res_valid and res_* stable, init_ready=0, no strobes; res_ready=1 -> res_valid=0 next cycle and init_ready=1.
- Assert rst asynchronously between clock edges during STEP1 -> start_s0, start_s1, busy and res_valid go to 0 without waiting for clk; a fresh init then runs to a correct result.
- init_valid held high continuously across two jobs -> second word accepted only after the DONE handshake; each job returns its own result.
